// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and shared-ALU signal bundle for alu_arbiter
interface alu_arbiter_if #(
    parameter int DW = 16,
    parameter int RW = 38
);
    logic          req0_valid;
    logic [1:0]    req0_op;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic          req0_gnt;
    logic          req1_valid;
    logic [1:0]    req1_op;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic          req1_gnt;
    logic          rsp0_valid;
    logic [RW-1:0] rsp0_data;
    logic          rsp0_ready;
    logic          rsp1_valid;
    logic [RW-1:0] rsp1_data;
    logic          rsp1_ready;
    logic [1:0]    alu_control;
    logic [DW-1:0] alu_in1;
    logic [DW-1:0] alu_in2;
    logic [RW-1:0] alu_result;
    logic          busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, alu_result,
        output req0_gnt, req1_gnt,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output alu_control, alu_in1, alu_in2, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, alu_result,
        input  req0_gnt, req1_gnt,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  alu_control, alu_in1, alu_in2, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared fixed-latency ALU
module alu_arbiter #(
    parameter int LATENCY = 3,
    parameter int DW      = 16,
    parameter int RW      = 38
) (
    input logic         clk,
    input logic         reset,
    alu_arbiter_if.slave bus
);
    logic               ptr;
    logic [LATENCY:0]   sr_valid;
    logic [LATENCY:0]   sr_tag;
    logic               rsp0_valid_q;
    logic               rsp1_valid_q;
    logic [RW-1:0]      rsp0_data_q;
    logic [RW-1:0]      rsp1_data_q;
    logic [1:0]         alu_control_q;
    logic [DW-1:0]      alu_in1_q;
    logic [DW-1:0]      alu_in2_q;
    logic               elig0;
    logic               elig1;
    logic               cand0;
    logic               cand1;
    logic               gnt0;
    logic               gnt1;

    // Eligibility looks at registered state only, so an ack this cycle frees the requester next cycle.
    always_comb begin
        elig0 = ~(|(sr_valid & ~sr_tag)) & ~rsp0_valid_q;
        elig1 = ~(|(sr_valid & sr_tag)) & ~rsp1_valid_q;
        cand0 = bus.req0_valid & elig0;
        cand1 = bus.req1_valid & elig1;
        gnt0  = reset & cand0 & (~ptr | ~cand1);
        gnt1  = reset & cand1 & (ptr | ~cand0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr           <= 1'b0;
            sr_valid      <= '0;
            sr_tag        <= '0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_data_q   <= '0;
            rsp1_data_q   <= '0;
            alu_control_q <= 2'b00;
            alu_in1_q     <= '0;
            alu_in2_q     <= '0;
        end else begin
            if (gnt0 | gnt1) begin
                ptr <= gnt0;
            end
            sr_valid <= {sr_valid[LATENCY-1:0], gnt0 | gnt1};
            sr_tag   <= {sr_tag[LATENCY-1:0], gnt1};

            if (gnt0) begin
                alu_control_q <= bus.req0_op;
                alu_in1_q     <= bus.req0_a;
                alu_in2_q     <= bus.req0_b;
            end else if (gnt1) begin
                alu_control_q <= bus.req1_op;
                alu_in1_q     <= bus.req1_a;
                alu_in2_q     <= bus.req1_b;
            end else begin
                alu_control_q <= 2'b00;
                alu_in1_q     <= '0;
                alu_in2_q     <= '0;
            end

            // A capture and an ack for the same requester cannot coincide: it is ineligible while in flight.
            if (sr_valid[LATENCY] && !sr_tag[LATENCY]) begin
                rsp0_valid_q <= 1'b1;
                rsp0_data_q  <= bus.alu_result;
            end else if (rsp0_valid_q && bus.rsp0_ready) begin
                rsp0_valid_q <= 1'b0;
                rsp0_data_q  <= '0;
            end

            if (sr_valid[LATENCY] && sr_tag[LATENCY]) begin
                rsp1_valid_q <= 1'b1;
                rsp1_data_q  <= bus.alu_result;
            end else if (rsp1_valid_q && bus.rsp1_ready) begin
                rsp1_valid_q <= 1'b0;
                rsp1_data_q  <= '0;
            end
        end
    end

    assign bus.req0_gnt    = gnt0;
    assign bus.req1_gnt    = gnt1;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp0_data   = rsp0_data_q;
    assign bus.rsp1_data   = rsp1_data_q;
    assign bus.alu_control = alu_control_q;
    assign bus.alu_in1     = alu_in1_q;
    assign bus.alu_in2     = alu_in2_q;
    assign bus.busy        = (|sr_valid) | rsp0_valid_q | rsp1_valid_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a 3-cycle ALU model
module tb_alu_arbiter;
    localparam int LAT = 3;
    localparam int DW  = 16;
    localparam int RW  = 38;

    typedef struct {
        int          req;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [37:0] exp;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [37:0] q0 [$];
    logic [37:0] q1 [$];
    logic [37:0] pipe [3];
    vec_t vecs [6];

    alu_arbiter_if #(.DW(DW), .RW(RW)) bus ();

    alu_arbiter #(.LATENCY(LAT), .DW(DW), .RW(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] alu_f(logic [1:0] op, logic [15:0] a, logic [15:0] b);
        logic [37:0] ea;
        logic [37:0] eb;
        ea = 38'(a);
        eb = 38'(b);
        case (op)
            2'b00:   return ea * eb;
            2'b01:   return ea + eb;
            2'b10:   return ea & eb;
            default: return ea | eb;
        endcase
    endfunction

    always @(posedge clk) begin
        pipe[0] <= alu_f(bus.alu_control, bus.alu_in1, bus.alu_in2);
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign bus.alu_result = pipe[2];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected result queued at grant, compared when the response is consumed.
    always @(negedge clk) begin
        if (!reset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (bus.req0_gnt | bus.req1_gnt) chk("one_gnt", 64'(bus.req0_gnt & bus.req1_gnt), 0);
            if (bus.req0_gnt) q0.push_back(alu_f(bus.req0_op, bus.req0_a, bus.req0_b));
            if (bus.req1_gnt) q1.push_back(alu_f(bus.req1_op, bus.req1_a, bus.req1_b));
            if (bus.rsp0_valid && bus.rsp0_ready) begin
                if (q0.size() == 0) chk("sb0_empty", 1, 0);
                else chk("sb0_data", 64'(bus.rsp0_data), 64'(q0.pop_front()));
            end
            if (bus.rsp1_valid && bus.rsp1_ready) begin
                if (q1.size() == 0) chk("sb1_empty", 1, 0);
                else chk("sb1_data", 64'(bus.rsp1_data), 64'(q1.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int n, logic v, logic [1:0] op, logic [15:0] a, logic [15:0] b);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic set_ready(int n, logic r);
        if (n == 0) bus.rsp0_ready = r;
        else bus.rsp1_ready = r;
    endtask

    function automatic logic gnt(int n);
        return (n == 0) ? bus.req0_gnt : bus.req1_gnt;
    endfunction

    function automatic logic rvalid(int n);
        return (n == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction

    function automatic logic [37:0] rdata(int n);
        return (n == 0) ? bus.rsp0_data : bus.rsp1_data;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            step();
            bus.rsp0_ready = 1'b1;
            bus.rsp1_ready = 1'b1;
            @(negedge clk);
            if (!bus.busy) done = 1'b1;
        end
        chk("drain_idle", 64'(done), 1);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
    endtask

    task automatic run_vec(vec_t v);
        int   lat;
        logic got;
        lat = 0;
        got = 1'b0;
        step();
        set_req(v.req, 1'b1, v.op, v.a, v.b);
        @(negedge clk);
        chk("vec_gnt", 64'(gnt(v.req)), 1);
        for (int k = 1; k <= 20 && !got; k++) begin
            step();
            set_req(v.req, 1'b0, 2'b00, 16'h0, 16'h0);
            @(negedge clk);
            if (k == 1) begin
                chk("vec_alu_in1", 64'(bus.alu_in1), 64'(v.a));
                chk("vec_alu_in2", 64'(bus.alu_in2), 64'(v.b));
                chk("vec_alu_ctl", 64'(bus.alu_control), 64'(v.op));
            end
            if (rvalid(v.req)) begin
                got = 1'b1;
                lat = k;
            end
        end
        chk("vec_latency", 64'(lat), 5);
        chk("vec_data", 64'(rdata(v.req)), 64'(v.exp));
        step();
        set_ready(v.req, 1'b1);
        step();
        set_ready(v.req, 1'b0);
        @(negedge clk);
        chk("vec_cleared", 64'(rvalid(v.req)), 0);
    endtask

    initial begin
        int nfair;
        int who;
        vecs[0] = '{req: 0, op: 2'b00, a: 16'd7,    b: 16'd6,    exp: 38'd42};
        vecs[1] = '{req: 1, op: 2'b01, a: 16'd1,    b: 16'd1,    exp: 38'd2};
        vecs[2] = '{req: 0, op: 2'b00, a: 16'h0700, b: 16'h0001, exp: 38'h700};
        vecs[3] = '{req: 1, op: 2'b00, a: 16'hFFFF, b: 16'hFFFF, exp: 38'hFFFE0001};
        vecs[4] = '{req: 0, op: 2'b01, a: 16'hFFFF, b: 16'hFFFF, exp: 38'h1FFFE};
        vecs[5] = '{req: 1, op: 2'b00, a: 16'h0000, b: 16'h1234, exp: 38'h0};

        set_req(0, 1'b0, 2'b00, 16'h0, 16'h0);
        set_req(1, 1'b0, 2'b00, 16'h0, 16'h0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // Reset state, with a request held to show grants are suppressed.
        reset = 1'b0;
        set_req(0, 1'b1, 2'b01, 16'd9, 16'd9);
        step();
        step();
        @(negedge clk);
        chk("rst_gnt0", 64'(bus.req0_gnt), 0);
        chk("rst_rsp0_valid", 64'(bus.rsp0_valid), 0);
        chk("rst_rsp1_valid", 64'(bus.rsp1_valid), 0);
        chk("rst_rsp0_data", 64'(bus.rsp0_data), 0);
        chk("rst_alu_ctl", 64'(bus.alu_control), 0);
        chk("rst_alu_in1", 64'(bus.alu_in1), 0);
        chk("rst_busy", 64'(bus.busy), 0);
        set_req(0, 1'b0, 2'b00, 16'h0, 16'h0);
        step();
        reset = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Contention right after reset: requester 0 wins, requester 1 follows.
        do_reset();
        set_req(0, 1'b1, 2'b01, 16'd1, 16'd1);
        set_req(1, 1'b1, 2'b00, 16'd2, 16'd2);
        @(negedge clk);
        chk("cont_gnt0", 64'(bus.req0_gnt), 1);
        chk("cont_gnt1_lose", 64'(bus.req1_gnt), 0);
        step();
        set_req(0, 1'b0, 2'b00, 16'h0, 16'h0);
        @(negedge clk);
        chk("cont_gnt1", 64'(bus.req1_gnt), 1);
        step();
        set_req(1, 1'b0, 2'b00, 16'h0, 16'h0);
        step();
        step();
        step();
        @(negedge clk);
        chk("cont_rsp0_valid", 64'(bus.rsp0_valid), 1);
        chk("cont_rsp0_data", 64'(bus.rsp0_data), 2);
        chk("cont_rsp1_early", 64'(bus.rsp1_valid), 0);
        step();
        @(negedge clk);
        chk("cont_rsp1_valid", 64'(bus.rsp1_valid), 1);
        chk("cont_rsp1_data", 64'(bus.rsp1_data), 4);
        drain();

        // Blocked: unacked result holds off further grants; operand changes are ignored.
        step();
        set_req(0, 1'b1, 2'b01, 16'd3, 16'd4);
        @(negedge clk);
        chk("blk_gnt", 64'(bus.req0_gnt), 1);
        for (int k = 1; k <= 10; k++) begin
            step();
            set_req(0, 1'b1, 2'b01, 16'(k), 16'(k));
            @(negedge clk);
            chk("blk_no_gnt", 64'(bus.req0_gnt), 0);
            if (k >= 5) chk("blk_data_stable", 64'(bus.rsp0_data), 7);
        end
        step();
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        chk("blk_gnt_on_ack", 64'(bus.req0_gnt), 0);
        step();
        bus.rsp0_ready = 1'b0;
        @(negedge clk);
        chk("blk_gnt_after_ack", 64'(bus.req0_gnt), 1);
        step();
        set_req(0, 1'b0, 2'b00, 16'h0, 16'h0);
        drain();

        // Fairness under continuous contention with immediate acks.
        do_reset();
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        nfair = 0;
        for (int c = 0; c < 400 && nfair < 20; c++) begin
            if (c > 0) step();
            set_req(0, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
            set_req(1, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
            @(negedge clk);
            if (bus.req0_gnt | bus.req1_gnt) begin
                who = bus.req1_gnt ? 1 : 0;
                chk("fair_order", 64'(who), 64'(nfair % 2));
                nfair++;
            end
        end
        chk("fair_count", 64'(nfair), 20);
        step();
        set_req(0, 1'b0, 2'b00, 16'h0, 16'h0);
        set_req(1, 1'b0, 2'b00, 16'h0, 16'h0);
        drain();

        // Reset while an operation is in flight.
        step();
        set_req(0, 1'b1, 2'b00, 16'd5, 16'd5);
        @(negedge clk);
        chk("mid_gnt", 64'(bus.req0_gnt), 1);
        step();
        set_req(0, 1'b0, 2'b00, 16'h0, 16'h0);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        set_req(0, 1'b1, 2'b01, 16'd8, 16'd8);
        set_req(1, 1'b1, 2'b01, 16'd9, 16'd9);
        @(negedge clk);
        chk("mid_busy", 64'(bus.busy), 0);
        chk("mid_first_gnt0", 64'(bus.req0_gnt), 1);
        chk("mid_first_gnt1", 64'(bus.req1_gnt), 0);
        step();
        set_req(0, 1'b0, 2'b00, 16'h0, 16'h0);
        set_req(1, 1'b0, 2'b00, 16'h0, 16'h0);
        step();
        @(negedge clk);
        chk("mid_no_rsp0", 64'(bus.rsp0_valid), 0);
        chk("mid_no_rsp1", 64'(bus.rsp1_valid), 0);
        drain();

        chk("sb0_left", 64'(q0.size()), 0);
        chk("sb1_left", 64'(q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 3, cycles from ALU operands presented to alu_result valid (range 1-8).
REQ-002 SHALL have parameter DW, default 16, operand width.
REQ-003 SHALL have parameter RW, default 38, result width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-007 reqN_op  input  2  ALU control code for requester N.
REQ-008 reqN_a, reqN_b  input  DW  operands for requester N.
REQ-009 reqN_gnt  output  1  combinational; operation accepted this cycle.
REQ-010 rspN_valid  output  1  result available for requester N.
REQ-011 rspN_data  output  RW  result for requester N.
REQ-012 rspN_ready  input  1  requester N consumes result.
REQ-013 alu_control  output  2  registered control to shared ALU.
REQ-014 alu_in1, alu_in2  output  DW  registered operands to shared ALU.
REQ-015 alu_result  input  RW  shared ALU output.
REQ-016 busy  output  1  high while any operation in flight or any rspN_valid high.

Function
REQ-017 Requester N eligible only when no operation of N is in flight and rspN_valid=0 (max one outstanding per requester).
REQ-018 reqN_gnt = reqN_valid & eligible(N) & arbitration win; at most one gnt per cycle.
REQ-019 Arbitration round-robin: 1-bit pointer names preferred requester; if preferred not valid/eligible, other valid eligible requester wins.
REQ-020 On grant to N, pointer SHALL become 1-N next cycle; pointer unchanged when no grant.
REQ-021 Grant at cycle T: alu_control/alu_in1/alu_in2 SHALL carry reqN_op/a/b during T+1 only.
REQ-022 Cycles with no grant: alu_control=2'b00, alu_in1=0, alu_in2=0 in following cycle.
REQ-023 In-flight tracking: LATENCY+1-deep shift register of {valid, tag}; entry entering at T+1 exits at T+1+LATENCY.
REQ-024 At exit cycle, alu_result SHALL be captured into rsp{tag}_data; rsp{tag}_valid=1 from T+2+LATENCY.
REQ-025 rspN_valid/rspN_data SHALL hold stable until cycle with rspN_ready=1; cleared next cycle.
REQ-026 Eligibility uses state before rspN_ready takes effect: requester N not grantable in cycle its result is acknowledged; grantable next cycle.
REQ-027 Both requesters valid and eligible: pointer owner wins; loser's gnt=0, loser retains request.
REQ-028 Issue throughput: one grant per cycle when requesters alternate; same requester minimum issue interval LATENCY+3 cycles with immediate ack.
REQ-029 rspN_ready while rspN_valid=0 SHALL be ignored.
REQ-030 reqN_op/a/b sampled only in granted cycle; changes otherwise ignored.

Reset
REQ-031 reset=0 at rising edge: pointer=0, shift register cleared, rsp0_valid=rsp1_valid=0, rsp0_data=rsp1_data=0, alu_control=2'b00, alu_in1=alu_in2=0, busy=0.
REQ-032 reqN_gnt SHALL be 0 in every cycle reset=0.
REQ-033 Reset mid-operation: in-flight operations discarded; no rspN_valid for them after reset released.
REQ-034 First cycle after reset release: requesters grantable, requester 0 preferred.

Verification (bench ALU model: LATENCY=3, result = a*b for op 00, a+b for op 01, zero-extended to 38 bits)
REQ-035 Single: req0 op=00 a=7 b=6 at T -> gnt0 at T; alu_in1=7, alu_in2=6 at T+1; rsp0_valid=1, rsp0_data=42 at T+5.
REQ-036 Contention after reset: req0 (op=01 a=1 b=1) and req1 (op=00 a=2 b=2) both at T -> gnt0 at T, gnt1 at T+1; rsp0_data=2 at T+5, rsp1_data=4 at T+6.
REQ-037 Blocked: req0 held valid with rsp0_ready=0 -> no second gnt0 until ready; rsp0_data stable; ack at cycle A -> gnt0 at A+1 earliest.
REQ-038 Fairness: both valid continuously, all responses acked immediately -> grants strictly alternate 0,1,0,1 over 20 grants.
REQ-039 Reset mid-flight: grant at T, reset=0 at T+2 -> no rspN_valid at T+5, busy=0 at T+3.
REQ-040 Large operands: op=00 a=0x0700 b=0x0001 -> rsp data 0x0700; a=0xFFFF b=0xFFFF -> 0xFFFE0001, upper bits zero.
